// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle draw controller.
// Optional build macro used by this slice: DRAW_OUTLINE_EN (outline-only plotting).
package draw_pkg;

  localparam int COORD_W   = 9;
  localparam int COLOUR_W  = 9;
  localparam int DEF_MAX_W = 320;
  localparam int DEF_MAX_H = 240;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  // Limit a requested dimension to the largest legal rectangle size.
  function automatic logic [COORD_W-1:0] clamp_dim(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/draw_control_if.sv
// Scheduler/datapath-facing bundle of the rectangle draw controller.
// With DRAW_OUTLINE_EN defined an extra 'outline' request bit is present.
interface draw_control_if;
  import draw_pkg::*;

  logic               start;
  logic [COORD_W-1:0] w_in;
  logic [COORD_W-1:0] h_in;
`ifdef DRAW_OUTLINE_EN
  logic               outline;
`endif
  logic               ld_xy;
  logic               ld_colour;
  logic               ld_pos;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               plot;
  logic               busy;
  logic               done;

  // Requester side: issues draws and watches progress.
  modport master (
`ifdef DRAW_OUTLINE_EN
    output outline,
`endif
    output start, w_in, h_in,
    input  ld_xy, ld_colour, ld_pos, dx, dy, plot, busy, done
  );

  // Controller side.
  modport slave (
`ifdef DRAW_OUTLINE_EN
    input  outline,
`endif
    input  start, w_in, h_in,
    output ld_xy, ld_colour, ld_pos, dx, dy, plot, busy, done
  );

endinterface

// File: rtl/draw_control_raster_counter.sv
// Row-major dx/dy scan counter for one rectangle.
// With DRAW_OUTLINE_EN defined it also flags pixels on the rectangle border.
module raster_counter
  import draw_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic [COORD_W-1:0] dx_o,
  output logic [COORD_W-1:0] dy_o,
`ifdef DRAW_OUTLINE_EN
  output logic               edge_o,
`endif
  output logic               last_o
);

  logic [COORD_W-1:0] dx_q, dx_d;
  logic [COORD_W-1:0] dy_q, dy_d;
  logic [COORD_W-1:0] w_m1, h_m1;

  assign w_m1 = w_i - COORD_W'(1);
  assign h_m1 = h_i - COORD_W'(1);

  // Advance along the row, wrapping to the next row at the right edge.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en_i) begin
      if (dx_q == w_m1) begin
        dx_d = '0;
        dy_d = dy_q + COORD_W'(1);
      end else begin
        dx_d = dx_q + COORD_W'(1);
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_o   = dx_q;
  assign dy_o   = dy_q;
  assign last_o = (dx_q == w_m1) && (dy_q == h_m1);
`ifdef DRAW_OUTLINE_EN
  assign edge_o = (dx_q == '0) || (dx_q == w_m1) || (dy_q == '0) || (dy_q == h_m1);
`endif

endmodule

// File: rtl/draw_control.sv
// Rectangle rasterisation sequencer: load origin/colour, scan w*h offsets,
// and emit a plot strobe one cycle behind each datapath position load.
// Build option DRAW_OUTLINE_EN: latched 'outline' suppresses interior plots.
module draw_control
  import draw_pkg::*;
#(
  parameter int MAX_W = DEF_MAX_W,
  parameter int MAX_H = DEF_MAX_H
) (
  input  logic          clock,
  input  logic          resetn,
  draw_control_if.slave bus
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic               plot_q, plot_d;
  logic               ld_xy_c, ld_colour_c, ld_pos_c;
  logic               in_draw;
  logic               last_px;
  logic [COORD_W-1:0] cnt_dx, cnt_dy;
`ifdef DRAW_OUTLINE_EN
  logic               outline_q, outline_d;
  logic               edge_px;
`endif

  assign in_draw = (state_q == S_DRAW);

  raster_counter u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (!in_draw),
    .en_i   (in_draw),
    .w_i    (w_q),
    .h_i    (h_q),
    .dx_o   (cnt_dx),
    .dy_o   (cnt_dy),
`ifdef DRAW_OUTLINE_EN
    .edge_o (edge_px),
`endif
    .last_o (last_px)
  );

  // Next-state, size latching and strobe decode.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    ld_xy_c     = 1'b0;
    ld_colour_c = 1'b0;
    ld_pos_c    = 1'b0;
`ifdef DRAW_OUTLINE_EN
    outline_d   = outline_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          w_d = clamp_dim(bus.w_in, COORD_W'(MAX_W));
          h_d = clamp_dim(bus.h_in, COORD_W'(MAX_H));
`ifdef DRAW_OUTLINE_EN
          outline_d = bus.outline;
`endif
          state_d = ((w_d == '0) || (h_d == '0)) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        ld_xy_c     = 1'b1;
        ld_colour_c = 1'b1;
        state_d     = S_DRAW;
      end
      S_DRAW: begin
        ld_pos_c = 1'b1;
        if (last_px) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A scanned pixel is written one cycle later, once the datapath has its position.
  always_comb begin
`ifdef DRAW_OUTLINE_EN
    plot_d = ld_pos_c && (!outline_q || edge_px);
`else
    plot_d = ld_pos_c;
`endif
  end

  // Control state, latched request and plot register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      plot_q    <= 1'b0;
`ifdef DRAW_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      plot_q    <= plot_d;
`ifdef DRAW_OUTLINE_EN
      outline_q <= outline_d;
`endif
    end
  end

  assign bus.ld_xy     = ld_xy_c;
  assign bus.ld_colour = ld_colour_c;
  assign bus.ld_pos    = ld_pos_c;
  assign bus.dx        = in_draw ? cnt_dx : '0;
  assign bus.dy        = in_draw ? cnt_dy : '0;
  assign bus.plot      = plot_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: doc/draw_control.md
Name: draw_control

Overview:
- FSM that sequences the graphics datapath to rasterise one filled rectangle (card face, chip, text block) into the VGA frame buffer.
- Drives the datapath's load strobes and its dx/dy offsets in row-major order, and emits a plot strobe aligned with the datapath's registered xpos/ypos/colour.
- Sits between the game-level drawing scheduler (start/busy/done handshake) and the datapath + VGA adapter write port.

Parameters:
- MAX_W, 320, largest legal rectangle width in pixels; larger w_in is clamped to this.
- MAX_H, 240, largest legal rectangle height in pixels; larger h_in is clamped to this.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- start  in  1  request one rectangle draw; sampled in S_IDLE only.
- w_in  in  9  rectangle width; latched with start.
- h_in  in  9  rectangle height; latched with start.
- ld_xy  out  1  datapath strobe: load X_IN/Y_IN origin.
- ld_colour  out  1  datapath strobe: load COLOUR_DATA.
- ld_pos  out  1  datapath strobe: xpos/ypos <= origin + offset.
- dx  out  9  column offset to datapath.
- dy  out  9  row offset to datapath.
- plot  out  1  VGA write enable, valid with the datapath xpos/ypos/colour outputs.
- busy  out  1  high from S_LOAD through S_DONE inclusive.
- done  out  1  one-cycle pulse when the rectangle is finished.

Behaviour:
- Reset (asynchronous, any state): state=S_IDLE, all outputs 0, latched width/height 0. An in-flight draw is abandoned with no done pulse.
- S_IDLE: all strobes 0. On start=1, latch min(w_in,MAX_W) and min(h_in,MAX_H) and go to S_LOAD. If either latched size is 0, go instead directly to S_DONE.
- S_LOAD (1 cycle): ld_xy=1, ld_colour=1, dx=dy=0. Next state is S_DRAW.
- S_DRAW: ld_pos=1 every cycle with the current dx,dy. dx increments each cycle. When dx=w-1, dx returns to 0 and dy increments. Leave after (dx,dy)=(w-1,h-1) and go to S_FLUSH.
- S_FLUSH (1 cycle): ld_pos=0. This cycle carries the plot for the last pixel. Next state is S_DONE.
- S_DONE (1 cycle): done=1, busy=1, then S_IDLE. start is not accepted in this cycle.
- plot is a register: plot(t) = ld_pos(t-1). It is high for exactly w*h consecutive cycles, starting the cycle after the first ld_pos.
- Latency for an N=w*h pixel draw with start sampled at cycle 0:
  - S_LOAD at cycle 1.
  - ld_pos on cycles 2..N+1.
  - plot on cycles 3..N+2.
  - done on cycle N+3.
  - Zero-size draw: done on cycle 1, no plot.
- start while busy=1 is ignored. There is no queueing; the requester must wait for done.
- dx/dy outputs are 0 in every state other than S_DRAW.
- The controller does not clip to the screen: origin+offset wraps mod 512 inside the datapath.
- w_in and h_in changing mid-draw has no effect.

Optional Feature:
- Macro: DRAW_OUTLINE_EN.
- Defined:
  - Extra input port `outline` (1 bit), latched with start.
  - When the latched outline=1, plot is suppressed for interior pixels, i.e. those with 0<dx<w-1 and 0<dy<h-1.
  - The scan still visits all w*h positions, so the cycle count and done timing are unchanged.
  - A rectangle with w≤2 or h≤2 is fully plotted.
- Undefined: the port is absent and every scanned pixel is plotted (filled rectangle).

Decomposition:
- Package draw_pkg holds:
  - COORD_W=9, COLOUR_W=9.
  - State enum: S_IDLE, S_LOAD, S_DRAW, S_FLUSH, S_DONE.
  - Default MAX_W/MAX_H constants.
- One sub-module, raster_counter:
  - 2-D dx/dy counter with an enable and a synchronous clear.
  - Provides a last flag (dx=w-1 && dy=h-1) and, under DRAW_OUTLINE_EN, an edge flag.
- The FSM and plot register stay in draw_control.

Test Plan:
- Reset then start with w=3, h=2 → ld_xy/ld_colour high in cycle 1; ld_pos cycles 2..7 with (dx,dy)=(0,0),(1,0),(2,0),(0,1),(1,1),(2,1); plot cycles 3..8; done in cycle 9 only.
- start with w=0, h=5 → done in cycle 1, no ld_pos, no plot, busy high for one cycle.
- start with w=4, h=4, then pulse start again in cycle 5 → second start ignored; exactly 16 plots; one done.
- resetn driven low asynchronously mid-S_DRAW (between clock edges) → plot, busy, ld_pos and dx/dy go to 0 immediately; no done; a fresh start after release draws normally.
- w_in=400, h_in=1 → clamped to 320; exactly 320 plots; last dx=319.
- With DRAW_OUTLINE_EN, outline=1, w=4, h=3 → 10 plots; pixels (1,1) and (2,1) are not plotted; done still in cycle 15.
